tick_divider_bank: RTL
======================

# tick_divider_bank

Multi-channel programmable clock-enable divider. Each channel counts qualified input ticks and emits a one-`clk`-wide output tick every (divisor+1) input ticks. Divisors can be rewritten at run time, and channels can be phase-aligned with a common restart. The block sits between a base tick source (e.g. a 1 µs or 1 ms strobe) and the LED/PWM/UART consumers on the 3.3 MHz iCEblink40 `clk` domain.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `WIDTH`, 24: divisor/counter width in bits.
- `DEFAULT_DIV`, 3300000: divisor loaded into every channel on reset; must fit in `WIDTH`.

Ports:
- `clk`, in, 1: system clock; all logic on its rising edge.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low; deassert synchronised externally.
- `tick_in`, in, 1: qualified count enable; one count per `clk` cycle it is high.
- `sync`, in, 1: restart all channel counters to 0.
- `ch_en`, in, CHANNELS: per-channel run enable.
- `wr_en`, in, 1: divisor write strobe.
- `wr_chan`, in, max(1,$clog2(CHANNELS)): target channel of the write.
- `wr_div`, in, WIDTH: new divisor D.
- `wr_mode`, in, 1: 0 = pulse only, 1 = also toggle `level_out`.
- `tick_out`, out, CHANNELS: one-cycle terminal-count pulses, registered.
- `level_out`, out, CHANNELS: square wave that toggles on each terminal count in toggle mode.
- `pending`, out, CHANNELS: a written divisor is waiting to be applied.

## Operation
Per channel state:
- `cnt[WIDTH]`: counter.
- `div_act`: active divisor.
- `div_shadow`, `mode_shadow`: staged write.
- `pend`: write-pending flag.
- `mode_act`: active mode.
- `lvl`: toggle level.

Reset (`rst_n`=0):
- `cnt`=0, `div_act`=`div_shadow`=DEFAULT_DIV, `mode_act`=0, `pend`=0.
- `tick_out`=0, `level_out`=0, `pending`=0.

Count (channel enabled, `tick_in`=1, `sync`=0):
- If `cnt` != `div_act`: `cnt`++.
- Else (terminal): `cnt`=0, `tick_out`=1 next cycle, `lvl` toggles if `mode_act`=1.

Otherwise `tick_out`=0. A channel with D=0 pulses on every `tick_in`.

Write:
- `wr_en`=1 with `wr_chan`<CHANNELS loads `div_shadow`/`mode_shadow` and sets `pend`.
- `wr_chan` >= CHANNELS: the write is ignored.
- A second write before the apply point overwrites the shadow; the last write wins.

Apply point, when `div_act`←`div_shadow`, `mode_act`←`mode_shadow`, and `pend`←0:
- at a terminal count,
- at `sync`,
- on any cycle where the channel is disabled.

The current period always completes with the old divisor.

Disabled channel (`ch_en`[i]=0):
- `cnt` held, `tick_out`=0, `lvl` held.
- Pending writes apply immediately.

`sync`=1:
- Every channel sets `cnt`=0, `tick_out`=0, applies any pending write.
- `lvl` is cleared to 0, so toggle outputs realign.

## Timing
Latency:
- `tick_out` asserts the cycle after the terminal `tick_in` edge (1-cycle registered latency).
- Period = (D+1) `tick_in` cycles.

Priority per cycle: `rst_n` > `sync` > write-apply > count.

Simultaneous events:
- `wr_en` on the same cycle as a terminal count of that channel: the new value is staged, not applied. The terminal uses the old `div_act`, and `pend` stays 1 until the next terminal.
- `wr_en` + `sync` on the same cycle: the write lands in the shadow and is applied by that `sync` (`div_act` updates next cycle).
- Wrap-around: `cnt` never exceeds `div_act`. Writing D smaller than the current `cnt` has no effect until applied, so no overflow path exists.
- `pending` reflects `pend` registered, valid the cycle after `wr_en`.
- Mid-operation `rst_n` assertion clears all state asynchronously. Outputs go 0 within the same cycle.

## Configuration
`TICK_DIVIDER_BANK_TOGGLE_EN`:
- Defined: toggle mode is compiled in; `level_out` behaves as above.
- Undefined:
  - `mode_shadow`/`mode_act`/`lvl` logic is removed.
  - `wr_mode` is ignored.
  - `level_out` is tied to 0.
  - `tick_out` behaviour is identical.

## Test plan
- **Reset default:** `DEFAULT_DIV`=9, `tick_in`=1 continuously, `ch_en`=all-1 -> every channel pulses `tick_out` once every 10 cycles. First pulse is on the 11th cycle after reset release.
- **Deferred write:** ch1 D=9 running, write D=3 at `cnt`=5 -> `pending`[1]=1. Current period ends at `cnt`=9, then pulses every 4 ticks. `pending`[1] clears at that terminal.
- **Write collision:** write ch0 on its terminal cycle -> pulse still emitted, old period used once more, `pending`[0] stays 1 until the next terminal.
- **Sync:** channels at different phases, assert `sync` 1 cycle -> all `cnt`=0, no `tick_out` that cycle. Subsequent pulses coincide for equal D.
- **Disable and hold:** `tick_in` gated 1-of-3 and ch2 disabled for 20 cycles mid-count -> ch2 resumes from the held `cnt`. `tick_out`[2]=0 while disabled; out-of-range `wr_chan` changes nothing.
- **Toggle:** with `TICK_DIVIDER_BANK_TOGGLE_EN`, `wr_mode`=1, D=1 -> `level_out` toggles every 2 ticks. Without the macro, `level_out` stays 0.

Source files
------------

// File: rtl/tick_divider_bank.sv
// Multi-channel programmable clock-enable divider with staged divisor writes and common restart.
// Optional toggle outputs are compiled in with `define TICK_DIVIDER_BANK_TOGGLE_EN.
module tick_divider_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEFAULT_DIV = 3300000
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              tick_in,
  input  logic                                              sync,
  input  logic [CHANNELS-1:0]                               ch_en,
  input  logic                                              wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
  input  logic [WIDTH-1:0]                                  wr_div,
  input  logic                                              wr_mode,
  output logic [CHANNELS-1:0]                               tick_out,
  output logic [CHANNELS-1:0]                               level_out,
  output logic [CHANNELS-1:0]                               pending
);

  localparam int unsigned      CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

  logic                wr_ok;
  logic [CHANNELS-1:0] wr_hit;
  logic [CHANNELS-1:0] term;

  assign wr_ok = wr_en && (32'(wr_chan) < CHANNELS);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_shadow;
    logic [WIDTH-1:0] div_stage;
    logic             tick_q;
    logic             pend_q;

    assign wr_hit[i]  = wr_ok && (wr_chan == CW'(i));
    assign term[i]    = tick_in && ch_en[i] && (cnt == div_act);
    // A write arriving this cycle is visible to a same-cycle apply via sync or disable
    assign div_stage  = wr_hit[i] ? wr_div : div_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt        <= '0;
        div_act    <= DIV_RST;
        div_shadow <= DIV_RST;
        tick_q     <= 1'b0;
        pend_q     <= 1'b0;
      end else begin
        tick_q     <= 1'b0;
        div_shadow <= div_stage;
        if (sync || !ch_en[i]) begin
          if (sync) cnt <= '0;
          div_act <= div_stage;
          pend_q  <= 1'b0;
        end else begin
          if (wr_hit[i]) pend_q <= 1'b1;
          if (tick_in) begin
            if (cnt == div_act) begin
              // Terminal applies only what was staged before this cycle
              cnt     <= '0;
              tick_q  <= 1'b1;
              div_act <= div_shadow;
              if (!wr_hit[i]) pend_q <= 1'b0;
            end else begin
              cnt <= cnt + WIDTH'(1);
            end
          end
        end
      end
    end

    assign tick_out[i] = tick_q;
    assign pending[i]  = pend_q;
  end

`ifdef TICK_DIVIDER_BANK_TOGGLE_EN
  for (genvar i = 0; i < CHANNELS; i++) begin : g_tog
    logic mode_shadow;
    logic mode_act;
    logic mode_stage;
    logic lvl;

    assign mode_stage = wr_hit[i] ? wr_mode : mode_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_shadow <= 1'b0;
        mode_act    <= 1'b0;
        lvl         <= 1'b0;
      end else begin
        mode_shadow <= mode_stage;
        if (sync) begin
          lvl      <= 1'b0;
          mode_act <= mode_stage;
        end else if (!ch_en[i]) begin
          mode_act <= mode_stage;
        end else if (term[i]) begin
          if (mode_act) lvl <= ~lvl;
          mode_act <= mode_shadow;
        end
      end
    end

    assign level_out[i] = lvl;
  end
`else
  logic unused_wr_mode;
  assign unused_wr_mode = wr_mode;
  assign level_out      = '0;
`endif

endmodule
